// File: rtl/pkg_mips.sv
// Shared widths and the write-back payload used between pipeline stages and the register bank.
package pkg_mips;

    localparam int unsigned LARGURA_DADO = 32;
    localparam int unsigned LARGURA_END  = 5;
    localparam int unsigned NUM_REGS     = 32;

    // One pending register write: destination and value.
    typedef struct packed {
        logic [LARGURA_END-1:0]  endereco;
        logic [LARGURA_DADO-1:0] dado;
    } wb_entry_t;

endpackage

// File: rtl/unidade_writeback_fifo_wb.sv
// Synchronous FIFO of write-back entries; also exposes every slot and its valid bit for hazard tracking.
module fifo_wb
    import pkg_mips::*;
#(
    parameter int unsigned PROFUNDIDADE = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  wb_entry_t                    entrada,
    output wb_entry_t                    cabeca,
    output wb_entry_t [PROFUNDIDADE-1:0] entradas,
    output logic [PROFUNDIDADE-1:0]      valido,
    output logic                         cheio,
    output logic                         vazio
);

    localparam int unsigned LARG_PTR = $clog2(PROFUNDIDADE);
    localparam int unsigned LARG_CNT = LARG_PTR + 1;

    wb_entry_t [PROFUNDIDADE-1:0] mem;
    logic [LARG_PTR-1:0]          ptr_rd;
    logic [LARG_PTR-1:0]          ptr_wr;
    logic [LARG_CNT-1:0]          contagem;

    // Storage write; payload needs no reset since validity comes from the count.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[ptr_wr] <= entrada;
        end
    end

    // Pointers and occupancy; pointers wrap naturally because depth is a power of two.
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_rd   <= '0;
            ptr_wr   <= '0;
            contagem <= '0;
        end else begin
            if (push) begin
                ptr_wr <= ptr_wr + LARG_PTR'(1);
            end
            if (pop) begin
                ptr_rd <= ptr_rd + LARG_PTR'(1);
            end
            case ({push, pop})
                2'b10:   contagem <= contagem + LARG_CNT'(1);
                2'b01:   contagem <= contagem - LARG_CNT'(1);
                default: contagem <= contagem;
            endcase
        end
    end

    // Status flags, head view and per-slot validity (slot is live if it lies within count of the read pointer).
    always_comb begin
        logic [LARG_PTR-1:0] distancia;
        cheio    = (contagem == LARG_CNT'(PROFUNDIDADE));
        vazio    = (contagem == '0);
        cabeca   = mem[ptr_rd];
        entradas = mem;
        valido   = '0;
        for (int unsigned i = 0; i < PROFUNDIDADE; i++) begin
            distancia = LARG_PTR'(i) - ptr_rd;
            valido[i] = (LARG_CNT'(distancia) < contagem);
        end
    end

    a_sem_overflow:  assert property (@(posedge clock) disable iff (reset) !(push && cheio));
    a_sem_underflow: assert property (@(posedge clock) disable iff (reset) !(pop && vazio));

endmodule

// File: rtl/unidade_writeback.sv
// Write-back initiator: arbitrates load/ALU results into a FIFO and drains one bank write per cycle.
module unidade_writeback
    import pkg_mips::*;
#(
    parameter int unsigned PROFUNDIDADE = 4,
    parameter bit          PROTEGE_R0   = 1'b0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    alu_valid,
    output logic                    alu_ready,
    input  logic [LARGURA_END-1:0]  alu_endereco,
    input  logic [LARGURA_DADO-1:0] alu_dado,
    input  logic                    ld_valid,
    output logic                    ld_ready,
    input  logic [LARGURA_END-1:0]  ld_endereco,
    input  logic [LARGURA_DADO-1:0] ld_dado,
    input  logic                    pausa_wb,
    output logic                    wb_en,
    output logic [LARGURA_END-1:0]  wb_endereco,
    output logic [LARGURA_DADO-1:0] wb_dado,
    output logic [NUM_REGS-1:0]     pendente,
    output logic                    cheio,
    output logic                    vazio
);

    wb_entry_t                    entrada;
    wb_entry_t                    cabeca;
    wb_entry_t [PROFUNDIDADE-1:0] entradas;
    logic [PROFUNDIDADE-1:0]      valido;
    logic                         aceita_ld;
    logic                         aceita_alu;
    logic                         push;
    logic                         pop;
    logic [LARGURA_END-1:0]       ultimo_endereco;
    logic [LARGURA_DADO-1:0]      ultimo_dado;

    fifo_wb #(
        .PROFUNDIDADE (PROFUNDIDADE)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (push),
        .pop      (pop),
        .entrada  (entrada),
        .cabeca   (cabeca),
        .entradas (entradas),
        .valido   (valido),
        .cheio    (cheio),
        .vazio    (vazio)
    );

    // Fixed-priority acceptance (load over ALU) based only on registered occupancy; r0 filter.
    always_comb begin
        ld_ready   = !cheio && !reset;
        alu_ready  = !cheio && !ld_valid && !reset;
        aceita_ld  = ld_valid && ld_ready;
        aceita_alu = alu_valid && alu_ready;
        if (aceita_ld) begin
            entrada.endereco = ld_endereco;
            entrada.dado     = ld_dado;
        end else begin
            entrada.endereco = alu_endereco;
            entrada.dado     = alu_dado;
        end
        push = (aceita_ld || aceita_alu)
               && !(PROTEGE_R0 && (entrada.endereco == '0));
    end

    // Drain the head whenever the bank port is free; a reset cycle never issues a write.
    always_comb begin
        pop         = !vazio && !pausa_wb && !reset;
        wb_en       = pop;
        wb_endereco = pop ? cabeca.endereco : ultimo_endereco;
        wb_dado     = pop ? cabeca.dado     : ultimo_dado;
    end

    // Remember the last written fields so the write port holds steady while idle.
    always_ff @(posedge clock) begin
        if (reset) begin
            ultimo_endereco <= '0;
            ultimo_dado     <= '0;
        end else if (pop) begin
            ultimo_endereco <= cabeca.endereco;
            ultimo_dado     <= cabeca.dado;
        end
    end

    // Pending-write bitmap: one-hot destination of every live FIFO slot, OR-reduced.
    always_comb begin
        pendente = '0;
        for (int unsigned i = 0; i < PROFUNDIDADE; i++) begin
            if (valido[i]) begin
                pendente[entradas[i].endereco] = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_unidade_writeback.sv
// Self-checking bench: two instances (r0 unprotected / protected) against a queue-based reference model.
module tb_unidade_writeback;

    localparam int unsigned PROF = 4;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset = 1'b1;
    logic        alu_valid = 1'b0, ld_valid = 1'b0, pausa_wb = 1'b0;
    logic [4:0]  alu_endereco = '0, ld_endereco = '0;
    logic [31:0] alu_dado = '0, ld_dado = '0;

    logic [1:0]       alu_ready, ld_ready, wb_en, cheio, vazio;
    logic [1:0][4:0]  wb_endereco;
    logic [1:0][31:0] wb_dado, pendente;

    unidade_writeback #(.PROFUNDIDADE(PROF), .PROTEGE_R0(1'b0)) dut0 (
        .clock(clock), .reset(reset),
        .alu_valid(alu_valid), .alu_ready(alu_ready[0]), .alu_endereco(alu_endereco), .alu_dado(alu_dado),
        .ld_valid(ld_valid), .ld_ready(ld_ready[0]), .ld_endereco(ld_endereco), .ld_dado(ld_dado),
        .pausa_wb(pausa_wb), .wb_en(wb_en[0]), .wb_endereco(wb_endereco[0]), .wb_dado(wb_dado[0]),
        .pendente(pendente[0]), .cheio(cheio[0]), .vazio(vazio[0])
    );

    unidade_writeback #(.PROFUNDIDADE(PROF), .PROTEGE_R0(1'b1)) dut1 (
        .clock(clock), .reset(reset),
        .alu_valid(alu_valid), .alu_ready(alu_ready[1]), .alu_endereco(alu_endereco), .alu_dado(alu_dado),
        .ld_valid(ld_valid), .ld_ready(ld_ready[1]), .ld_endereco(ld_endereco), .ld_dado(ld_dado),
        .pausa_wb(pausa_wb), .wb_en(wb_en[1]), .wb_endereco(wb_endereco[1]), .wb_dado(wb_dado[1]),
        .pendente(pendente[1]), .cheio(cheio[1]), .vazio(vazio[1])
    );

    int checks = 0;
    int errors = 0;
    int ciclo  = 0;

    // Reference state: a queue of {endereco, dado} per instance, last written fields, and register banks.
    logic [36:0] fila0[$];
    logic [36:0] fila1[$];
    logic [4:0]  ult_end[2];
    logic [31:0] ult_dado[2];
    logic [31:0] banco_dut[2][32];
    logic [31:0] banco_mod[2][32];
    int          escritas_r0[2];

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        checks++;
        if (obs !== esp) begin
            errors++;
            $display("FAIL %s @ciclo %0d: got 0x%08h expected 0x%08h", tag, ciclo, obs, esp);
        end
    endtask

    // Check one instance's outputs for the current cycle, then advance its model across the next edge.
    task automatic modelo(input int k);
        logic [36:0] q[$];
        logic        lr, ar, pop_m;
        logic [31:0] pend;
        if (k == 0) q = fila0; else q = fila1;

        lr    = (q.size() < PROF) && !reset;
        ar    = lr && !ld_valid;
        pop_m = (q.size() > 0) && !pausa_wb && !reset;

        verifica($sformatf("ld_ready[%0d]", k), 32'(ld_ready[k]), 32'(lr));
        verifica($sformatf("alu_ready[%0d]", k), 32'(alu_ready[k]), 32'(ar));
        verifica($sformatf("wb_en[%0d]", k), 32'(wb_en[k]), 32'(pop_m));

        if (!reset || ciclo > 0) begin
            pend = '0;
            foreach (q[i]) pend[q[i][36:32]] = 1'b1;
            verifica($sformatf("pendente[%0d]", k), pendente[k], pend);
            verifica($sformatf("cheio[%0d]", k), 32'(cheio[k]), 32'(q.size() == PROF));
            verifica($sformatf("vazio[%0d]", k), 32'(vazio[k]), 32'(q.size() == 0));
            if (pop_m) begin
                ult_end[k]  = q[0][36:32];
                ult_dado[k] = q[0][31:0];
            end
            if (!reset) begin
                verifica($sformatf("wb_endereco[%0d]", k), 32'(wb_endereco[k]), 32'(ult_end[k]));
                verifica($sformatf("wb_dado[%0d]", k), wb_dado[k], ult_dado[k]);
            end
        end

        if (wb_en[k]) banco_dut[k][wb_endereco[k]] = wb_dado[k];
        if (wb_en[k] && wb_endereco[k] == 5'd0) escritas_r0[k]++;
        if (pop_m) banco_mod[k][q[0][36:32]] = q[0][31:0];

        if (reset) begin
            q.delete();
            ult_end[k]  = '0;
            ult_dado[k] = '0;
        end else begin
            if (pop_m) void'(q.pop_front());
            if (lr && ld_valid) begin
                if (!(k == 1 && ld_endereco == 5'd0)) q.push_back({ld_endereco, ld_dado});
            end else if (ar && alu_valid) begin
                if (!(k == 1 && alu_endereco == 5'd0)) q.push_back({alu_endereco, alu_dado});
            end
        end

        if (k == 0) fila0 = q; else fila1 = q;
    endtask

    task automatic passo(input logic rst, input logic lv, input logic [4:0] le, input logic [31:0] ldd,
                         input logic av, input logic [4:0] ae, input logic [31:0] ad, input logic pz);
        @(negedge clock);
        reset = rst; ld_valid = lv; ld_endereco = le; ld_dado = ldd;
        alu_valid = av; alu_endereco = ae; alu_dado = ad; pausa_wb = pz;
        #1;
        modelo(0);
        modelo(1);
        ciclo++;
    endtask

    task automatic ocioso(input int n, input logic pz);
        for (int i = 0; i < n; i++) passo(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, pz);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            ult_end[k] = '0; ult_dado[k] = '0; escritas_r0[k] = 0;
            for (int r = 0; r < 32; r++) begin
                banco_dut[k][r] = '0; banco_mod[k][r] = '0;
            end
        end

        // Reset and a single ALU write to r5.
        passo(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
        passo(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
        ocioso(1, 1'b0);
        passo(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h0000_0008, 1'b0);
        ocioso(2, 1'b0);

        // Load and ALU together: load wins, ALU retried next cycle.
        passo(1'b0, 1'b1, 5'd3, 32'hAA, 1'b1, 5'd4, 32'hBB, 1'b0);
        passo(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'hBB, 1'b0);
        ocioso(3, 1'b0);

        // Fill under pause, overfill attempt, then release.
        for (int i = 0; i < 5; i++) passo(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'(10 + i), 32'(100 + i), 1'b1);
        ocioso(6, 1'b0);

        // Two writes to r7 in order.
        passo(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h1, 1'b0);
        passo(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h2, 1'b0);
        ocioso(3, 1'b0);

        // Write to r0: discarded only by the protected instance.
        passo(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0);
        ocioso(2, 1'b0);
        verifica("r0_escrito[0]", 32'(escritas_r0[0]), 32'd1);
        verifica("r0_escrito[1]", 32'(escritas_r0[1]), 32'd0);

        // Three queued entries dropped by a one-edge reset.
        for (int i = 0; i < 3; i++) passo(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'(20 + i), 32'hDEAD_0000 + 32'(i), 1'b1);
        passo(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0);
        ocioso(4, 1'b0);
        verifica("reset_descarta", banco_dut[0][20], 32'd0);

        // Randomized traffic with occasional pauses and resets.
        for (int i = 0; i < 3000; i++) begin
            logic [4:0] ea, el;
            ea = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            el = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            passo(($urandom_range(0, 99) == 0),
                  1'($urandom_range(0, 1)), el, $urandom,
                  1'($urandom_range(0, 1)), ea, $urandom,
                  ($urandom_range(0, 3) == 0));
        end
        ocioso(PROF + 2, 1'b0);

        // Final register contents must match what the model wrote.
        for (int k = 0; k < 2; k++)
            for (int r = 0; r < 32; r++)
                verifica($sformatf("banco[%0d][%0d]", k, r), banco_dut[k][r], banco_mod[k][r]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/unidade_writeback.md
Name: unidade_writeback

Overview:
- Write-side initiator for banco_registradores: collects results from the ALU and the load path and issues exactly one register write per cycle on the bank's write port (endereco_regd/data_in).
- Buffers results in a small FIFO and arbitrates between the two sources.
- Exposes a 32-bit pending-write bitmap so decode can detect RAW hazards against queued writes.
- Sits between execute/memory stages and banco_registradores.

Parameters:
PROFUNDIDADE, 4, FIFO entries; power of two, ≥2
PROTEGE_R0, 0, when 1, results addressed to register 0 are accepted but discarded (not enqueued)

Ports:
clock  in  1  system clock, all state on posedge
reset  in  1  synchronous, active-high; sampled on posedge clock
alu_valid  in  1  ALU result present
alu_ready  out  1  ALU result accepted this cycle when alu_valid&alu_ready
alu_endereco  in  5  ALU destination register
alu_dado  in  32  ALU result
ld_valid  in  1  load result present
ld_ready  out  1  load result accepted when ld_valid&ld_ready
ld_endereco  in  5  load destination register
ld_dado  in  32  load data
pausa_wb  in  1  bank write port unavailable this cycle; hold FIFO head
wb_en  out  1  write qualifier to bank-side gating
wb_endereco  out  5  drives banco_registradores.endereco_regd
wb_dado  out  32  drives banco_registradores.data_in
pendente  out  32  bit r = 1 iff a valid FIFO entry targets register r
cheio  out  1  FIFO full
vazio  out  1  FIFO empty

Behaviour:
- Reset (clock edge with reset=1): FIFO flushed (rd/wr pointers 0, count 0); outputs wb_en=0, wb_endereco=0, wb_dado=0, pendente=0, vazio=1, cheio=0. alu_ready=ld_ready=0 while reset is asserted. A reset mid-operation drops all queued writes; no bank write is issued for them.
- Acceptance: at most one push per cycle, fixed priority load > ALU.
  - ld_ready = !cheio.
  - alu_ready = !cheio & !ld_valid.
  - ready depends only on registered count, never on same-cycle pop; no pass-through when full.
- PROTEGE_R0=1 with destination 0: handshake completes normally, nothing enqueued, pendente unaffected.
- Drain: when !vazio & !pausa_wb, head is popped at the clock edge.
  - Outputs are registered from the head: wb_en=1, wb_endereco/wb_dado = head fields during the cycle the entry is popped.
  - When vazio or pausa_wb, wb_en=0; wb_endereco/wb_dado hold their last values.
- Latency: result accepted at edge N, FIFO empty, no pausa → wb_en=1 with that entry during cycle N+1 → bank write at edge N+1.
- Throughput: 1 write/cycle sustained.
- Simultaneous push and pop: count unchanged. Allowed at any occupancy where push is legal, including count=PROFUNDIDADE−1.
- Ordering: strict FIFO; two writes to the same register are emitted in acceptance order.
- pendente: combinational OR-reduction over valid entries (one-hot of endereco). Covers entries in FIFO, including the head currently driving wb. Bit clears the cycle after the last matching entry pops.
- Pointers: log2(PROFUNDIDADE) bits, wrap modulo depth. Count register is log2(PROFUNDIDADE)+1 bits.
- No overflow or underflow is possible by construction. Assertions: push while cheio; pop while vazio.

Decomposition:
- Shared package pkg_mips: constants LARGURA_DADO=32, LARGURA_END=5, NUM_REGS=32; typedef wb_entry_t {logic [4:0] endereco; logic [31:0] dado;}.
- One sub-module: fifo_wb (parameterised sync FIFO of wb_entry_t with push/pop/cheio/vazio and an entry-valid vector for pendente).
- Arbiter and PROTEGE_R0 filtering stay in the top.

Test Plan:
- Reset then single ALU result r5=0x0000_0008 at edge N → wb_en=1, wb_endereco=5, wb_dado=8 in cycle N+1; pendente[5]=1 during N+1, 0 in N+2.
- ld_valid and alu_valid both high (ld r3=0xAA, alu r4=0xBB) → ld accepted, alu_ready=0 that cycle; alu accepted next cycle; writes emitted r3 then r4.
- pausa_wb=1 while 4 ALU results pushed → cheio=1, alu_ready=0, wb_en=0; release pausa → 4 writes in consecutive cycles, in push order; vazio=1 after.
- Two pushes to r7 (0x1, then 0x2) → pendente[7] stays 1 until the second pops; bank ends with r7=0x2.
- PROTEGE_R0=1, ALU result to r0=0xFFFF_FFFF → handshake completes, wb_en never asserts, pendente=0; with PROTEGE_R0=0 → write to r0 issued.
- 3 entries queued, reset asserted for one edge → next cycle vazio=1, pendente=0, wb_en=0, and no queued write ever appears.
